// File: rtl/regfile_param.sv
// regfile_param
//   Multi-port register file with a self-clearing power-up sweep, a
//   handshaked debug write port and two test-status flags.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset (restarts the clear sweep)
//     we_i         core write enable
//     waddr_i      core write address
//     wdata_i      core write data
//     raddr_i      NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//     rdata_o      NUM_RD packed read data,     port k at [k*DATA_W +: DATA_W]
//     dbg_req_i    debug write request (level, held until dbg_ack_o)
//     dbg_addr_i   debug read/write address
//     dbg_wdata_i  debug write data
//     dbg_ack_o    one-cycle pulse the cycle after a debug write commits
//     dbg_rdata_o  debug read data (no write bypass)
//     init_busy_o  high while the clear sweep runs
//     over_o       test-complete flag, inverse of regs[OVER_IDX][0]
//     succ_o       test-success flag,  inverse of regs[SUCC_IDX][0]
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned OVER_IDX = 26,
  parameter int unsigned SUCC_IDX = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  input  logic                     dbg_req_i,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  input  logic [DATA_W-1:0]        dbg_wdata_i,
  output logic                     dbg_ack_o,
  output logic [DATA_W-1:0]        dbg_rdata_o,
  output logic                     init_busy_o,
  output logic                     over_o,
  output logic                     succ_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] OVER_A = ADDR_W'(OVER_IDX);
  localparam logic [ADDR_W-1:0] SUCC_A = ADDR_W'(SUCC_IDX);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              dbg_ack_q, dbg_ack_d;

  // Storage is deliberately not reset; the sweep defines its contents.
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              run;
  logic              core_wr;
  logic              dbg_commit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign run     = (state_q == ST_RUN);
  assign core_wr = run && we_i && (waddr_i != '0);

  // Core writes (even dropped ones to address 0) block the debug port, and
  // the ack cycle blocks a second commit from a still-held request.
  assign dbg_commit = run && dbg_req_i && !we_i && !dbg_ack_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dbg_ack_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dbg_ack_d = dbg_commit;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      dbg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dbg_ack_q <= dbg_ack_d;
    end
  end

  // Single array write port shared by sweep, core and debug; the sources are
  // mutually exclusive by construction (state, and we_i gating the commit).
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!run) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
    end else if (core_wr) begin
      wr_en   = 1'b1;
      wr_addr = waddr_i;
      wr_data = wdata_i;
    end else if (dbg_commit && (dbg_addr_i != '0)) begin
      wr_en   = 1'b1;
      wr_addr = dbg_addr_i;
      wr_data = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports with core-write bypass.
  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (run && (raddr_i[k*ADDR_W +: ADDR_W] != '0)) begin
        if (we_i && (waddr_i == raddr_i[k*ADDR_W +: ADDR_W])) begin
          rdata_o[k*DATA_W +: DATA_W] = wdata_i;
        end else begin
          rdata_o[k*DATA_W +: DATA_W] = regs_q[raddr_i[k*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  always_comb begin
    dbg_rdata_o = '0;
    if (run && (dbg_addr_i != '0)) begin
      dbg_rdata_o = regs_q[dbg_addr_i];
    end
  end

  assign dbg_ack_o   = dbg_ack_q;
  assign init_busy_o = !run;
  assign over_o      = run && !regs_q[OVER_A][0];
  assign succ_o      = run && !regs_q[SUCC_A][0];

endmodule
